// File: rtl/regfile_pkg.sv
// Shared widths, constants and helpers for the multi-port register file.
// Optional parity protection is enabled by defining REGFILE_PARITY_EN.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_ZERO     = 0;

  // Widest busy vector the popcount helper accepts; NUM_REGS must not exceed it.
  localparam int POP_MAX      = 1024;

  // Bit offset of element idx inside a packed per-port bus.
  function automatic int lsb(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] vec);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      if (vec[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// count of pending registers. Flush dominates issue, issue dominates writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_WR   = 2,
  parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [NUM_WR-1:0]        wb_en,
  input  logic [NUM_WR*ADDR_W-1:0] wb_addr,
  input  logic                     flush,
  output logic [NUM_REGS-1:0]      busy,
  output logic [CNT_W-1:0]         busy_cnt
);

  logic [NUM_REGS-1:0] busy_next;
  logic [POP_MAX-1:0]  busy_ext;

  // Later assignments override earlier ones, giving the priority order.
  always_comb begin
    busy_next = busy;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wb_en[p]) busy_next[wb_addr[lsb(p, ADDR_W) +: ADDR_W]] = 1'b0;
    end
    if (issue_en) busy_next[issue_addr] = 1'b1;
    busy_next[REG_ZERO] = 1'b0;
    if (flush) busy_next = '0;
  end

  always_comb begin
    busy_ext = '0;
    busy_ext[NUM_REGS-1:0] = busy_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= CNT_W'(popcount(busy_ext));
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass, debugger
// port and pending-write scoreboard. Define REGFILE_PARITY_EN for stored parity.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [NUM_WR-1:0]        wb_en,
  input  logic [NUM_WR*ADDR_W-1:0] wb_addr,
  input  logic [NUM_WR*DATA_W-1:0] wb_data,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic [CNT_W-1:0]         busy_cnt,
  output logic [NUM_RD-1:0]        parity_err
);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_RD-1:0]   rd_hit;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .flush      (flush),
    .busy       (busy),
    .busy_cnt   (busy_cnt)
  );

  // Ports are visited in ascending order so the highest index wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wb_en[p] && wb_addr[lsb(p, ADDR_W) +: ADDR_W] != ADDR_W'(REG_ZERO))
          mem[wb_addr[lsb(p, ADDR_W) +: ADDR_W]] <= wb_data[lsb(p, DATA_W) +: DATA_W];
      end
    end
  end

  always_comb begin : read_mux
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    rd_hit  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[lsb(i, ADDR_W) +: ADDR_W];
      rd_data[lsb(i, DATA_W) +: DATA_W] = mem[ra];
      for (int p = 0; p < NUM_WR; p++) begin
        if (wb_en[p] && wb_addr[lsb(p, ADDR_W) +: ADDR_W] == ra) begin
          rd_hit[i] = 1'b1;
          rd_data[lsb(i, DATA_W) +: DATA_W] = wb_data[lsb(p, DATA_W) +: DATA_W];
        end
      end
      // A same-cycle issue is deliberately invisible here; it belongs to a younger instruction.
      rd_busy[i] = busy[ra] & ~rd_hit[i];
      if (rst || ra == ADDR_W'(REG_ZERO)) begin
        rd_data[lsb(i, DATA_W) +: DATA_W] = '0;
        rd_busy[i] = 1'b0;
      end
    end
  end

  always_comb begin
    dbg_data = mem[dbg_addr];
    for (int p = 0; p < NUM_WR; p++) begin
      if (wb_en[p] && wb_addr[lsb(p, ADDR_W) +: ADDR_W] == dbg_addr)
        dbg_data = wb_data[lsb(p, DATA_W) +: DATA_W];
    end
    if (rst || dbg_addr == ADDR_W'(REG_ZERO)) dbg_data = '0;
  end

`ifdef REGFILE_PARITY_EN
  logic [NUM_REGS-1:0] par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wb_en[p] && wb_addr[lsb(p, ADDR_W) +: ADDR_W] != ADDR_W'(REG_ZERO))
          par[wb_addr[lsb(p, ADDR_W) +: ADDR_W]] <= ^wb_data[lsb(p, DATA_W) +: DATA_W];
      end
    end
  end

  // Bypassed reads never touch storage, so they cannot report a stored-parity error.
  always_comb begin : parity_check
    logic [ADDR_W-1:0] pa;
    pa         = '0;
    parity_err = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      pa = rd_addr[lsb(i, ADDR_W) +: ADDR_W];
      if (!rst && pa != ADDR_W'(REG_ZERO) && !rd_hit[i] && (par[pa] != ^mem[pa]))
        parity_err[i] = 1'b1;
    end
  end
`else
  assign parity_err = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_mp;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 2;
  localparam int NUM_WR   = 2;
  localparam int CNT_W    = 6;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic [NUM_WR-1:0]        wb_en;
  logic [ADDR_W-1:0]        wb_a [NUM_WR];
  logic [DATA_W-1:0]        wb_d [NUM_WR];
  logic                     flush;
  logic [ADDR_W-1:0]        rd_a [NUM_RD];
  logic [NUM_WR*ADDR_W-1:0] wb_addr;
  logic [NUM_WR*DATA_W-1:0] wb_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [ADDR_W-1:0]        dbg_addr;
  logic [DATA_W-1:0]        dbg_data;
  logic [CNT_W-1:0]         busy_cnt;
  logic [NUM_RD-1:0]        parity_err;

  assign wb_addr = {wb_a[1], wb_a[0]};
  assign wb_data = {wb_d[1], wb_d[0]};
  assign rd_addr = {rd_a[1], rd_a[0]};

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] m_regs [NUM_REGS];
  bit                m_busy [NUM_REGS];
  logic [DATA_W-1:0] exp_q [$];

  // clock / reset
  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .busy_cnt   (busy_cnt),
    .parity_err (parity_err)
  );

  // reference model
  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (rst || a == 0) return '0;
    v = m_regs[a];
    for (int p = 0; p < NUM_WR; p++)
      if (wb_en[p] && wb_a[p] == a) v = wb_d[p];
    return v;
  endfunction

  function automatic bit exp_busy(input logic [ADDR_W-1:0] a);
    if (rst || a == 0) return 1'b0;
    for (int p = 0; p < NUM_WR; p++)
      if (wb_en[p] && wb_a[p] == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int n;
    n = 0;
    for (int r = 0; r < NUM_REGS; r++) if (m_busy[r]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // driver tasks
  task automatic idle();
    issue_en   = 1'b0;
    issue_addr = '0;
    wb_en      = '0;
    flush      = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      wb_a[p] = '0;
      wb_d[p] = '0;
    end
  endtask

  // Advance one clock edge, apply the spec rules to the model, return at negedge.
  task automatic step();
    bit nb [NUM_REGS];
    bit wr;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        wr = 1'b0;
        for (int p = 0; p < NUM_WR; p++)
          if (wb_en[p] && wb_a[p] == ADDR_W'(r)) wr = 1'b1;
        if (r == 0 || flush) nb[r] = 1'b0;
        else if (issue_en && issue_addr == ADDR_W'(r)) nb[r] = 1'b1;
        else if (wr) nb[r] = 1'b0;
        else nb[r] = m_busy[r];
      end
      for (int p = 0; p < NUM_WR; p++)
        if (wb_en[p] && wb_a[p] != 0) m_regs[wb_a[p]] = wb_d[p];
      for (int r = 0; r < NUM_REGS; r++) m_busy[r] = nb[r];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rd_a[0] = 5'd3; rd_a[1] = 5'd17; dbg_addr = 5'd3;
    step(); step();
    #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    checks++; if (rd_busy !== '0) begin errors++; $display("FAIL reset_rd_busy: got %b expected 0", rd_busy); end
    checks++; if (dbg_data !== '0) begin errors++; $display("FAIL reset_dbg: got %h expected 0", dbg_data); end
    checks++; if (busy_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", busy_cnt); end
    checks++; if (parity_err !== '0) begin errors++; $display("FAIL reset_parity: got %b expected 0", parity_err); end
    rst = 1'b0;
    #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL post_reset_rd: got %h expected 0", rd_data); end
  endtask

  task automatic test_mid_reset();
    idle();
    wb_en = 2'b01; wb_a[0] = 5'd5; wb_d[0] = 32'h1234;
    issue_en = 1'b1; issue_addr = 5'd8;
    step();
    idle();
    rd_a[0] = 5'd5; rd_a[1] = 5'd8; dbg_addr = 5'd5;
    #1;
    checks++; if (rd_data[31:0] !== 32'h1234) begin errors++; $display("FAIL mid_pre_r5: got %h expected 1234", rd_data[31:0]); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL mid_pre_cnt: got %0d expected 1", busy_cnt); end
    checks++; if (rd_busy !== 2'b10) begin errors++; $display("FAIL mid_pre_busy: got %b expected 10", rd_busy); end
    rst = 1'b1;
    model_clear();
    #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL mid_rst_rd: got %h expected 0", rd_data); end
    checks++; if (dbg_data !== '0) begin errors++; $display("FAIL mid_rst_dbg: got %h expected 0", dbg_data); end
    checks++; if (busy_cnt !== '0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", busy_cnt); end
    checks++; if (rd_busy !== '0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", rd_busy); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (rd_data[31:0] !== '0) begin errors++; $display("FAIL mid_post_r5: got %h expected 0", rd_data[31:0]); end
    checks++; if (busy_cnt !== '0) begin errors++; $display("FAIL mid_post_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_reg_zero();
    idle();
    wb_en = 2'b01; wb_a[0] = 5'd0; wb_d[0] = 32'hDEAD;
    issue_en = 1'b1; issue_addr = 5'd0;
    rd_a[0] = 5'd0; dbg_addr = 5'd0;
    #1;
    checks++; if (rd_data[31:0] !== '0) begin errors++; $display("FAIL r0_bypass: got %h expected 0", rd_data[31:0]); end
    step();
    idle();
    #1;
    checks++; if (rd_data[31:0] !== '0) begin errors++; $display("FAIL r0_stored: got %h expected 0", rd_data[31:0]); end
    checks++; if (dbg_data !== '0) begin errors++; $display("FAIL r0_dbg: got %h expected 0", dbg_data); end
    checks++; if (busy_cnt !== '0) begin errors++; $display("FAIL r0_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_same_addr();
    idle();
    wb_en = 2'b11;
    wb_a[0] = 5'd7; wb_d[0] = 32'h11;
    wb_a[1] = 5'd7; wb_d[1] = 32'h22;
    rd_a[0] = 5'd7; dbg_addr = 5'd7;
    #1;
    checks++; if (rd_data[31:0] !== 32'h22) begin errors++; $display("FAIL same_addr_bypass: got %h expected 22", rd_data[31:0]); end
    checks++; if (dbg_data !== 32'h22) begin errors++; $display("FAIL same_addr_dbg: got %h expected 22", dbg_data); end
    step();
    idle();
    #1;
    checks++; if (rd_data[31:0] !== 32'h22) begin errors++; $display("FAIL same_addr_stored: got %h expected 22", rd_data[31:0]); end
  endtask

  task automatic test_issue_wb();
    idle();
    issue_en = 1'b1; issue_addr = 5'd9;
    rd_a[0] = 5'd9;
    step();
    idle();
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL hazard_busy_c%0d: got %b expected 1", c, rd_busy[0]); end
      checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL hazard_cnt_c%0d: got %0d expected 1", c, busy_cnt); end
      step();
    end
    wb_en = 2'b01; wb_a[0] = 5'd9; wb_d[0] = 32'hCAFE;
    #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL hazard_wb_busy: got %b expected 0", rd_busy[0]); end
    checks++; if (rd_data[31:0] !== 32'hCAFE) begin errors++; $display("FAIL hazard_wb_data: got %h expected cafe", rd_data[31:0]); end
    step();
    idle();
    #1;
    checks++; if (busy_cnt !== '0) begin errors++; $display("FAIL hazard_done_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_issue_wb_same();
    idle();
    issue_en = 1'b1; issue_addr = 5'd4;
    wb_en = 2'b01; wb_a[0] = 5'd4; wb_d[0] = 32'h5;
    rd_a[0] = 5'd4;
    step();
    idle();
    #1;
    checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL issue_wins_busy: got %b expected 1", rd_busy[0]); end
    checks++; if (rd_data[31:0] !== 32'h5) begin errors++; $display("FAIL issue_wins_data: got %h expected 5", rd_data[31:0]); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL issue_wins_cnt: got %0d expected 1", busy_cnt); end
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] want;
    idle();
    flush = 1'b1;
    step();
    idle();
    for (int k = 1; k <= 3; k++) begin
      issue_en = 1'b1; issue_addr = ADDR_W'(k);
      step();
      idle();
      #1;
      want = CNT_W'(k);
      checks++; if (busy_cnt !== want) begin errors++; $display("FAIL flush_ramp_%0d: got %0d expected %0d", k, busy_cnt, want); end
    end
    flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd6;
    step();
    idle();
    rd_a[0] = 5'd6; rd_a[1] = 5'd2;
    #1;
    checks++; if (busy_cnt !== '0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", busy_cnt); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL flush_busy: got %b expected 00", rd_busy); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] exp;
    int cnt_want;
    for (int n = 0; n < 400; n++) begin
      issue_en   = 1'($urandom_range(0, 1));
      issue_addr = ADDR_W'($urandom_range(0, 15));
      wb_en      = NUM_WR'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 24) == 0);
      for (int p = 0; p < NUM_WR; p++) begin
        wb_a[p] = ADDR_W'($urandom_range(0, 15));
        wb_d[p] = $urandom;
      end
      for (int i = 0; i < NUM_RD; i++) rd_a[i] = ADDR_W'($urandom_range(0, 15));
      dbg_addr = ADDR_W'($urandom_range(0, 31));
      #1;
      for (int i = 0; i < NUM_RD; i++) exp_q.push_back(exp_read(rd_a[i]));
      for (int i = 0; i < NUM_RD; i++) begin
        exp = exp_q.pop_front();
        checks++; if (rd_data[i*DATA_W +: DATA_W] !== exp) begin errors++; $display("FAIL rand_rd%0d n=%0d: got %h expected %h", i, n, rd_data[i*DATA_W +: DATA_W], exp); end
        checks++; if (rd_busy[i] !== exp_busy(rd_a[i])) begin errors++; $display("FAIL rand_busy%0d n=%0d: got %b expected %b", i, n, rd_busy[i], exp_busy(rd_a[i])); end
      end
      checks++; if (dbg_data !== exp_read(dbg_addr)) begin errors++; $display("FAIL rand_dbg n=%0d: got %h expected %h", n, dbg_data, exp_read(dbg_addr)); end
      cnt_want = exp_cnt();
      checks++; if (busy_cnt !== CNT_W'(cnt_want)) begin errors++; $display("FAIL rand_cnt n=%0d: got %0d expected %0d", n, busy_cnt, cnt_want); end
      checks++; if (parity_err !== '0) begin errors++; $display("FAIL rand_parity n=%0d: got %b expected 0", n, parity_err); end
      step();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < NUM_RD; i++) rd_a[i] = '0;
    dbg_addr = '0;
    model_clear();
    test_reset();
    test_mid_reset();
    test_reg_zero();
    test_same_addr();
    test_issue_wb();
    test_issue_wb_same();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
